// File: rtl/change_payout_pkg.sv
//----------------------------------------------------------------------------
// Module  : vm_pkg
// Brief   : Shared coin values, payout FSM states and coin-select helpers.
// Revision: 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

package vm_pkg;

    localparam logic [10:0] VAL_Q = 11'd25;
    localparam logic [10:0] VAL_D = 11'd10;
    localparam logic [10:0] VAL_N = 11'd5;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SELECT = 3'd1,
        ST_EJECT  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_DONE   = 3'd4,
        ST_FAULT  = 3'd5
    } payout_state_t;

    typedef enum logic [1:0] {
        COIN_Q    = 2'd0,
        COIN_D    = 2'd1,
        COIN_N    = 2'd2,
        COIN_NONE = 2'd3
    } coin_sel_t;

    function automatic logic [10:0] coin_value(input coin_sel_t coin);
        case (coin)
            COIN_Q:  coin_value = VAL_Q;
            COIN_D:  coin_value = VAL_D;
            COIN_N:  coin_value = VAL_N;
            default: coin_value = 11'd0;
        endcase
    endfunction

    // Solenoid drive as {quarter, dime, nickel}
    function automatic logic [2:0] eject_mask(input coin_sel_t coin);
        case (coin)
            COIN_Q:  eject_mask = 3'b100;
            COIN_D:  eject_mask = 3'b010;
            COIN_N:  eject_mask = 3'b001;
            default: eject_mask = 3'b000;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/change_payout_if.sv
//----------------------------------------------------------------------------
// Module  : change_payout_if
// Brief   : Request, hopper and status signals of the coin payout controller.
// Revision: 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

interface change_payout_if;
    logic        start;
    logic [4:0]  quarter_cnt;
    logic [4:0]  dime_cnt;
    logic [4:0]  nickel_cnt;
    logic        coin_sense;
    logic        eject_q;
    logic        eject_d;
    logic        eject_n;
    logic        busy;
    logic        done;
    logic        fault;
    logic [10:0] paid_cents;

    modport master (
        output start, quarter_cnt, dime_cnt, nickel_cnt, coin_sense,
        input  eject_q, eject_d, eject_n, busy, done, fault, paid_cents
    );

    modport slave (
        input  start, quarter_cnt, dime_cnt, nickel_cnt, coin_sense,
        output eject_q, eject_d, eject_n, busy, done, fault, paid_cents
    );
endinterface

`default_nettype wire

// File: rtl/change_payout_pulse_timer.sv
//----------------------------------------------------------------------------
// Module  : pulse_timer
// Brief   : Loadable down-counter shared by the eject pulse and sensor wait.
// Revision: 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module pulse_timer #(
    parameter int WIDTH = 6
) (
    input  wire logic             clk2,
    input  wire logic             rst,
    input  wire logic             load,
    input  wire logic [WIDTH-1:0] value,
    output logic                  expired
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk2) begin
        if (rst) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= value;
        end else if (r_count != '0) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    // Loaded with N, the Nth cycle after the load is the last one
    assign expired = (r_count <= WIDTH'(1));

endmodule

`default_nettype wire

// File: rtl/change_payout.sv
//----------------------------------------------------------------------------
// Module  : change_payout
// Brief   : Coin hopper payout FSM: one coin per eject, sensor-confirmed.
// Revision: 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module change_payout
    import vm_pkg::*;
#(
    parameter int EJECT_W       = 4,
    parameter int SENSE_TIMEOUT = 50,
    parameter int MAX_RETRY     = 2
) (
    input wire logic       clk2,
    input wire logic       rst,
    change_payout_if.slave bus
);

    localparam int c_TMR_MAX = (EJECT_W > SENSE_TIMEOUT) ? EJECT_W : SENSE_TIMEOUT;
    localparam int c_TMR_W   = $clog2(c_TMR_MAX + 1);
    localparam int c_RTY_W   = $clog2(MAX_RETRY + 2);
    localparam logic [c_TMR_W-1:0] c_EJECT_VAL = c_TMR_W'(EJECT_W);
    localparam logic [c_TMR_W-1:0] c_SENSE_VAL = c_TMR_W'(SENSE_TIMEOUT);
    localparam logic [c_RTY_W-1:0] c_MAX_RETRY = c_RTY_W'(MAX_RETRY);

    payout_state_t     r_state;
    coin_sel_t         r_coin;
    logic [4:0]        r_q, r_d, r_n;
    logic [10:0]       r_paid;
    logic [c_RTY_W-1:0] r_retry;
    logic [2:0]        r_eject;
    logic              r_busy, r_done, r_fault, r_sensed;

    coin_sel_t          w_sel;
    logic               w_expired, w_confirm, w_credit, w_tmr_load;
    logic [c_TMR_W-1:0] w_tmr_val;

    always_comb begin
        if (r_q != 5'd0)      w_sel = COIN_Q;
        else if (r_d != 5'd0) w_sel = COIN_D;
        else if (r_n != 5'd0) w_sel = COIN_N;
        else                  w_sel = COIN_NONE;
    end

    // A sense pulse anywhere in the eject pulse confirms the coin at pulse end
    assign w_confirm = r_sensed | bus.coin_sense;
    assign w_credit  = ((r_state == ST_EJECT) && w_expired && w_confirm) ||
                       ((r_state == ST_WAIT)  && bus.coin_sense);

    always_comb begin
        w_tmr_load = 1'b0;
        w_tmr_val  = c_EJECT_VAL;
        if (r_state == ST_SELECT && w_sel != COIN_NONE) begin
            w_tmr_load = 1'b1;
        end else if (r_state == ST_EJECT && w_expired && !w_confirm) begin
            w_tmr_load = 1'b1;
            w_tmr_val  = c_SENSE_VAL;
        end else if (r_state == ST_WAIT && w_expired && !bus.coin_sense &&
                     r_retry < c_MAX_RETRY) begin
            w_tmr_load = 1'b1;
        end
    end

    pulse_timer #(
        .WIDTH (c_TMR_W)
    ) u_timer (
        .clk2    (clk2),
        .rst     (rst),
        .load    (w_tmr_load),
        .value   (w_tmr_val),
        .expired (w_expired)
    );

    always_ff @(posedge clk2) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_coin   <= COIN_NONE;
            r_q      <= '0;
            r_d      <= '0;
            r_n      <= '0;
            r_paid   <= '0;
            r_retry  <= '0;
            r_eject  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_fault  <= 1'b0;
            r_sensed <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_q     <= bus.quarter_cnt;
                        r_d     <= bus.dime_cnt;
                        r_n     <= bus.nickel_cnt;
                        r_paid  <= '0;
                        r_retry <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_SELECT;
                    end
                end
                ST_SELECT: begin
                    r_sensed <= 1'b0;
                    if (w_sel == COIN_NONE) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_coin  <= w_sel;
                        r_eject <= eject_mask(w_sel);
                        r_state <= ST_EJECT;
                    end
                end
                ST_EJECT: begin
                    if (bus.coin_sense) r_sensed <= 1'b1;
                    if (w_expired) begin
                        r_eject <= '0;
                        r_state <= w_confirm ? ST_SELECT : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (bus.coin_sense) begin
                        r_state <= ST_SELECT;
                    end else if (w_expired) begin
                        if (r_retry < c_MAX_RETRY) begin
                            r_retry  <= r_retry + c_RTY_W'(1);
                            r_eject  <= eject_mask(r_coin);
                            r_sensed <= 1'b0;
                            r_state  <= ST_EJECT;
                        end else begin
                            r_busy  <= 1'b0;
                            r_fault <= 1'b1;
                            r_state <= ST_FAULT;
                        end
                    end
                end
                ST_DONE:  r_state <= ST_IDLE;
                ST_FAULT: r_state <= ST_FAULT;
                default:  r_state <= ST_IDLE;
            endcase

            if (w_credit) begin
                r_paid  <= r_paid + coin_value(r_coin);
                r_retry <= '0;
                case (r_coin)
                    COIN_Q:  if (r_q != 5'd0) r_q <= r_q - 5'd1;
                    COIN_D:  if (r_d != 5'd0) r_d <= r_d - 5'd1;
                    COIN_N:  if (r_n != 5'd0) r_n <= r_n - 5'd1;
                    default: ;
                endcase
            end
        end
    end

    assign bus.eject_q    = r_eject[2];
    assign bus.eject_d    = r_eject[1];
    assign bus.eject_n    = r_eject[0];
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.fault      = r_fault;
    assign bus.paid_cents = r_paid;

endmodule

`default_nettype wire

// File: doc/change_payout.md
# change_payout

Sequential coin-hopper controller downstream of the change calculator. It captures the quarter/dime/nickel counts produced for a cancelled or over-paid transaction and ejects the coins one at a time. Each coin is confirmed by the hopper drop sensor before the next is ejected. The block reports progress (`paid_cents`), completion (`done`) and hopper failure (`fault`) back to the vending-machine top level.

## Interface
Parameters:
- `EJECT_W`, default 4: eject solenoid pulse width in clk2 cycles (≥1).
- `SENSE_TIMEOUT`, default 50: WAIT cycles allowed for a drop-sensor pulse before a retry (≥1).
- `MAX_RETRY`, default 2: re-ejects allowed per coin before a fault.

Ports:
- `clk2`, in, 1: system clock. All logic is on the rising edge.
- `rst`, in, 1: synchronous, active-high reset. Clock is clk2.
- `start`, in, 1: single-cycle request to pay out the counts on the `*_cnt` inputs.
- `quarter_cnt`, in, 5: quarters to pay, 0–31.
- `dime_cnt`, in, 5: dimes to pay, 0–31.
- `nickel_cnt`, in, 5: nickels to pay, 0–31.
- `coin_sense`, in, 1: hopper drop sensor. Single-cycle pulse, already synchronous to clk2.
- `eject_q`, out, 1: quarter solenoid drive.
- `eject_d`, out, 1: dime solenoid drive.
- `eject_n`, out, 1: nickel solenoid drive.
- `busy`, out, 1: high from the cycle after `start` is accepted until DONE or FAULT.
- `done`, out, 1: single-cycle pulse when the payout completes.
- `fault`, out, 1: sticky hopper failure flag.
- `paid_cents`, out, 11: running total of confirmed coin value in cents (maximum 1240).

## Operation
States: IDLE, SELECT, EJECT, WAIT, DONE, FAULT.
- IDLE:
  - On `start`, load the three counts into internal registers, clear `paid_cents`, clear the retry count, and go to SELECT.
  - `start` in any state other than IDLE is ignored.
- SELECT: choose the highest denomination with a non-zero remaining count, in the order quarter → dime → nickel.
  - If a denomination is non-zero, load the pulse timer with `EJECT_W` and go to EJECT.
  - If all counts are 0, go to DONE.
- EJECT:
  - Exactly one `eject_*` output, for the chosen denomination, is high for `EJECT_W` cycles.
  - Then load the timer with `SENSE_TIMEOUT` and go to WAIT.
- WAIT: all `eject_*` outputs are low; the timer counts down.
  - `coin_sense` seen: decrement that denomination's count, add its value (25/10/5) to `paid_cents`, clear the retry count, and go to SELECT.
  - Timer expires with retry < `MAX_RETRY`: increment retry and go to EJECT for the same coin.
  - Timer expires otherwise: go to FAULT.
- DONE: `done` is high for this cycle only, then return to IDLE. `paid_cents` holds its value until the next accepted `start`.
- FAULT:
  - `fault` = 1, all `eject_*` = 0, `busy` = 0.
  - Remaining counts and `paid_cents` are frozen.
  - Only `rst` leaves FAULT.
- Boundary rules:
  - A `coin_sense` during EJECT counts as confirmation for the current coin; the block then skips WAIT and goes to SELECT after the pulse ends.
  - A `coin_sense` in IDLE, SELECT, DONE or FAULT is ignored.
  - A second `coin_sense` within one coin's WAIT is ignored.
  - `rst` asserted mid-payout forces IDLE on the next edge and de-asserts all ejects immediately. Uncompleted coins are dropped.
  - Counts are never decremented below 0.
  - `paid_cents` is computed in 11 bits, so no overflow is possible.

## Timing
- Reset values: `eject_q`, `eject_d`, `eject_n`, `busy`, `done`, `fault` all 0; `paid_cents` = 0; state IDLE.
- Every output is a register output (no combinational path from input to output).
- `start` at edge t: state is SELECT and `busy` = 1 from t+1. The first eject is high from t+2 to t+1+`EJECT_W`.
- A sense pulse in WAIT at edge s:
  - `paid_cents` is updated at s+1.
  - The next eject rises at s+2.
- Per-coin latency with a sensor response in WAIT cycle k (1-based): 1 + `EJECT_W` + k cycles.
- All counts zero at `start` edge t: `done` at t+2, with `busy` high for 1 cycle.
- Timeout: FAULT is entered `(MAX_RETRY+1)·(EJECT_W+SENSE_TIMEOUT)` cycles after the coin's first EJECT.

## Structure
- Shared package `vm_pkg`:
  - Coin value constants `VAL_Q` = 25, `VAL_D` = 10, `VAL_N` = 5.
  - `payout_state_t` enum (3 bits).
  - Coin-select 2-bit typedef: Q, D, N, NONE.
- Sub-module `pulse_timer`:
  - Loadable down-counter sized `$clog2(max(EJECT_W, SENSE_TIMEOUT)+1)`.
  - Ports: `load`, `value`, `expired`.
  - Instanced once and shared by EJECT and WAIT.
- The remainder is a single FSM plus the count and accumulator registers.

## Test plan
- Reset: assert `rst` mid-EJECT → next cycle all ejects = 0, `busy` = 0, `paid_cents` = 0, state IDLE.
- Start q=2, d=1, n=0, sense 3 cycles into each WAIT → ejects in order Q, Q, D; `paid_cents` 25 → 50 → 60; single `done` pulse; `busy` drops with `done`.
- Start all zero → `done` two cycles after `start`, no eject activity, `paid_cents` = 0.
- Start n=1, no sense ever → 3 nickel pulses each 4 cycles wide, `fault` = 1 after 162 cycles, `busy` = 0; `start` then ignored until `rst`.
- Start d=1, first WAIT times out, sense on the retry → `paid_cents` = 10, `done`, no fault; sense during EJECT confirms the coin and skips WAIT.
- Start q=31, d=31, n=31, sense one cycle into each WAIT → final `paid_cents` = 1240, and a `start` pulse while `busy` does not reload the counts.
